// File: rtl/alu_seq_pkg.sv
// Shared definitions for the Mini-SRC sequencer: opcodes, state encoding and
// the R-format opcode decoder used by the control FSM and the ALU.
package alu_seq_pkg;

  localparam logic [4:0] OP_ADD  = 5'b00011;
  localparam logic [4:0] OP_SUB  = 5'b00100;
  localparam logic [4:0] OP_SHR  = 5'b00101;
  localparam logic [4:0] OP_SHRA = 5'b00110;
  localparam logic [4:0] OP_SHL  = 5'b00111;
  localparam logic [4:0] OP_ROR  = 5'b01000;
  localparam logic [4:0] OP_ROL  = 5'b01001;
  localparam logic [4:0] OP_AND  = 5'b01010;
  localparam logic [4:0] OP_OR   = 5'b01011;
  localparam logic [4:0] OP_HALT = 5'b11011;

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_T0   = 4'd1,
    S_T1   = 4'd2,
    S_T1W  = 4'd3,
    S_T2   = 4'd4,
    S_T3   = 4'd5,
    S_T4   = 4'd6,
    S_T5   = 4'd7,
    S_HALT = 4'd8
  } state_t;

  function automatic logic is_alu_op(input logic [4:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_SHR, OP_SHRA, OP_SHL,
      OP_ROR, OP_ROL, OP_AND, OP_OR: return 1'b1;
      default:                       return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Clearable up-counter for the memory-wait state; o_tc flags the cycle in
// which the number of wait cycles reaches MEM_TIMEOUT.
module mem_wait_timer #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic i_clock,
  input  logic i_clear_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  localparam int CW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(MEM_TIMEOUT - 1);

  logic [CW-1:0] r_cnt;

  // r_cnt holds the wait cycles already completed, so the current cycle is r_cnt+1.
  assign o_tc = (r_cnt == LIMIT);

  always_ff @(posedge i_clock) begin
    if (!i_clear_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en && !o_tc) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/alu_seq_ctrl.sv
// Multi-cycle control FSM for the Mini-SRC datapath: fetch with bounded memory
// wait, then R-format ALU execute; halts on halt/illegal opcode or bus error.
module alu_seq_ctrl
  import alu_seq_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic             stop,
  input  logic [31:0]      ir,
  input  logic             mem_ready,
  output logic             pc_out,
  output logic             mar_in,
  output logic             inc_pc,
  output logic             z_in,
  output logic             z_lo_out,
  output logic             pc_in,
  output logic             mem_read,
  output logic             mdr_in,
  output logic             mdr_out,
  output logic             ir_in,
  output logic             y_in,
  output logic             gra,
  output logic             grb,
  output logic             grc,
  output logic             r_out,
  output logic             r_in,
  output logic [4:0]       alu_op,
  output logic             run,
  output logic             illegal,
  output logic             bus_err,
  output logic [CNT_W-1:0] instr_count,
  output state_t           dbg_state
);

  state_t           r_state;
  logic             r_illegal;
  logic             r_bus_err;
  logic [CNT_W-1:0] r_instr_count;
  logic [4:0]       w_opcode;
  logic             w_tmr_tc;
  logic             w_unused_ir;

  assign w_opcode    = ir[31:27];
  assign w_unused_ir = ^ir[26:0];

  // T1 always precedes T1W, so clearing there restarts the count on every entry.
  mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
    .i_clock   (clock),
    .i_clear_n (clear),
    .i_clr     (r_state == S_T1),
    .i_en      (r_state == S_T1W),
    .o_tc      (w_tmr_tc)
  );

  always_ff @(posedge clock) begin
    if (!clear) begin
      r_state       <= S_IDLE;
      r_illegal     <= 1'b0;
      r_bus_err     <= 1'b0;
      r_instr_count <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (start) r_state <= S_T0;
        S_T0:   r_state <= S_T1;
        S_T1:   r_state <= S_T1W;
        S_T1W: begin
          if (mem_ready) begin
            r_state <= S_T2;
          end else if (w_tmr_tc) begin
            r_bus_err <= 1'b1;
            r_state   <= S_HALT;
          end
        end
        S_T2:   r_state <= S_T3;
        S_T3: begin
          if (is_alu_op(w_opcode)) begin
            r_state <= S_T4;
          end else begin
            if (w_opcode != OP_HALT) r_illegal <= 1'b1;
            r_state <= S_HALT;
          end
        end
        S_T4:   r_state <= S_T5;
        S_T5: begin
          r_instr_count <= r_instr_count + 1'b1;
          r_state       <= stop ? S_IDLE : S_T0;
        end
        S_HALT: r_state <= S_HALT;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // Strobes decode from the state register; T3/T4 also look at the live opcode
  // because the IR is only loaded at the end of T2.
  always_comb begin
    pc_out   = 1'b0;
    mar_in   = 1'b0;
    inc_pc   = 1'b0;
    z_in     = 1'b0;
    z_lo_out = 1'b0;
    pc_in    = 1'b0;
    mem_read = 1'b0;
    mdr_in   = 1'b0;
    mdr_out  = 1'b0;
    ir_in    = 1'b0;
    y_in     = 1'b0;
    gra      = 1'b0;
    grb      = 1'b0;
    grc      = 1'b0;
    r_out    = 1'b0;
    r_in     = 1'b0;
    alu_op   = 5'b0;
    case (r_state)
      S_T0: begin
        pc_out = 1'b1;
        mar_in = 1'b1;
        inc_pc = 1'b1;
        z_in   = 1'b1;
      end
      S_T1: begin
        z_lo_out = 1'b1;
        pc_in    = 1'b1;
      end
      S_T1W: begin
        mem_read = 1'b1;
        mdr_in   = 1'b1;
      end
      S_T2: begin
        mdr_out = 1'b1;
        ir_in   = 1'b1;
      end
      S_T3: begin
        if (is_alu_op(w_opcode)) begin
          gra   = 1'b1;
          r_out = 1'b1;
          y_in  = 1'b1;
        end
      end
      S_T4: begin
        grb    = 1'b1;
        r_out  = 1'b1;
        z_in   = 1'b1;
        alu_op = w_opcode;
      end
      S_T5: begin
        z_lo_out = 1'b1;
        grc      = 1'b1;
        r_in     = 1'b1;
      end
      default: ;
    endcase
  end

  assign run         = (r_state != S_IDLE) && (r_state != S_HALT);
  assign illegal     = r_illegal;
  assign bus_err     = r_bus_err;
  assign instr_count = r_instr_count;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl with MEM_TIMEOUT=4 and CNT_W=4 so the
// timeout limit and counter wrap are reachable in a short run.
module tb_alu_seq_ctrl;
  import alu_seq_pkg::*;

  localparam int MT = 4;
  localparam int CW = 4;

  logic          clock = 1'b0;
  logic          clear = 1'b0;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic          mem_ready = 1'b0;
  logic [31:0]   ir = 32'h0;
  logic          pc_out, mar_in, inc_pc, z_in, z_lo_out, pc_in, mem_read, mdr_in;
  logic          mdr_out, ir_in, y_in, gra, grb, grc, r_out, r_in;
  logic [4:0]    alu_op;
  logic          run, illegal, bus_err;
  logic [CW-1:0] instr_count;
  state_t        dbg_state;
  logic [15:0]   strb;

  int n_cmp = 0;
  int n_err = 0;

  alu_seq_ctrl #(.MEM_TIMEOUT(MT), .CNT_W(CW)) dut (
    .clock(clock), .clear(clear), .start(start), .stop(stop), .ir(ir),
    .mem_ready(mem_ready), .pc_out(pc_out), .mar_in(mar_in), .inc_pc(inc_pc),
    .z_in(z_in), .z_lo_out(z_lo_out), .pc_in(pc_in), .mem_read(mem_read),
    .mdr_in(mdr_in), .mdr_out(mdr_out), .ir_in(ir_in), .y_in(y_in), .gra(gra),
    .grb(grb), .grc(grc), .r_out(r_out), .r_in(r_in), .alu_op(alu_op), .run(run),
    .illegal(illegal), .bus_err(bus_err), .instr_count(instr_count),
    .dbg_state(dbg_state)
  );

  assign strb = {pc_out, mar_in, inc_pc, z_in, z_lo_out, pc_in, mem_read, mdr_in,
                 mdr_out, ir_in, y_in, gra, grb, grc, r_out, r_in};

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_cycle(input string tag, input state_t st,
                              input logic [15:0] sb, input logic [4:0] aop);
    chk({tag, ".state"}, 32'(dbg_state), 32'(st));
    chk({tag, ".strobes"}, 32'(strb), 32'(sb));
    chk({tag, ".alu_op"}, 32'(alu_op), 32'(aop));
    chk({tag, ".run"}, 32'(run), 32'((st != S_IDLE) && (st != S_HALT)));
  endtask

  task automatic check_reset(input string tag);
    expect_cycle(tag, S_IDLE, 16'h0000, 5'b0);
    chk({tag, ".illegal"}, 32'(illegal), 32'h0);
    chk({tag, ".bus_err"}, 32'(bus_err), 32'h0);
    chk({tag, ".count"}, 32'(instr_count), 32'h0);
  endtask

  // Hand-decoded strobe words, MSB pc_out ... LSB r_in.
  state_t      seq_st[7] = '{S_T0, S_T1, S_T1W, S_T2, S_T3, S_T4, S_T5};
  logic [15:0] seq_sb[7] = '{16'hF000, 16'h0C00, 16'h0300, 16'h00C0,
                             16'h0032, 16'h100A, 16'h0805};

  initial begin
    step();
    step();
    check_reset("reset");
    clear = 1'b1;

    // Add with memory ready; stop held high must only matter in T5.
    ir = 32'h1800_0000; mem_ready = 1'b1; start = 1'b1; stop = 1'b1;
    for (int i = 0; i < 7; i++) begin
      step();
      if (i == 0) start = 1'b0;
      expect_cycle("add", seq_st[i], seq_sb[i], (i == 5) ? 5'b00011 : 5'b0);
    end
    step();
    expect_cycle("add_end", S_IDLE, 16'h0000, 5'b0);
    chk("add_count", 32'(instr_count), 32'd1);

    // Memory ready arrives in the 4th (limit) wait cycle.
    mem_ready = 1'b0; start = 1'b1;
    step(); start = 1'b0;
    expect_cycle("wait_t0", S_T0, 16'hF000, 5'b0);
    step();
    expect_cycle("wait_t1", S_T1, 16'h0C00, 5'b0);
    for (int w = 0; w < 4; w++) begin
      step();
      if (w == 3) mem_ready = 1'b1;
      expect_cycle("wait_t1w", S_T1W, 16'h0300, 5'b0);
      chk("wait_no_err", 32'(bus_err), 32'h0);
    end
    for (int i = 3; i < 7; i++) begin
      step();
      expect_cycle("wait_exec", seq_st[i], seq_sb[i], (i == 5) ? 5'b00011 : 5'b0);
    end
    step();
    expect_cycle("wait_end", S_IDLE, 16'h0000, 5'b0);
    chk("wait_count", 32'(instr_count), 32'd2);
    chk("wait_bus_err", 32'(bus_err), 32'h0);

    // Timeout: four wait cycles without mem_ready, then HALT with bus_err.
    mem_ready = 1'b0; start = 1'b1;
    step(); start = 1'b0;
    step();
    for (int w = 0; w < 4; w++) begin
      step();
      expect_cycle("to_t1w", S_T1W, 16'h0300, 5'b0);
    end
    step();
    expect_cycle("to_halt", S_HALT, 16'h0000, 5'b0);
    chk("to_bus_err", 32'(bus_err), 32'h1);
    mem_ready = 1'b1; start = 1'b1;
    step(); step(); step();
    expect_cycle("to_stuck", S_HALT, 16'h0000, 5'b0);
    chk("to_stuck_err", 32'(bus_err), 32'h1);
    clear = 1'b0;
    step();
    check_reset("to_clear");
    clear = 1'b1; start = 1'b0;

    // Illegal opcode 11111.
    ir = 32'hF800_0000; start = 1'b1;
    step(); start = 1'b0;
    step(); step(); step(); step();
    expect_cycle("ill_t3", S_T3, 16'h0000, 5'b0);
    chk("ill_t3_flag", 32'(illegal), 32'h0);
    step();
    expect_cycle("ill_halt", S_HALT, 16'h0000, 5'b0);
    chk("ill_flag", 32'(illegal), 32'h1);
    clear = 1'b0; step(); clear = 1'b1;
    check_reset("ill_clear");

    // Halt opcode 11011.
    ir = 32'hD800_0000; start = 1'b1;
    step(); start = 1'b0;
    step(); step(); step(); step();
    expect_cycle("hlt_t3", S_T3, 16'h0000, 5'b0);
    step();
    expect_cycle("hlt_halt", S_HALT, 16'h0000, 5'b0);
    chk("hlt_illegal", 32'(illegal), 32'h0);
    clear = 1'b0; step(); clear = 1'b1;
    check_reset("hlt_clear");

    // stop and start together in T5, then wrap the 4-bit counter.
    ir = 32'h5800_0000; start = 1'b1; stop = 1'b1;
    for (int i = 0; i < 7; i++) step();
    expect_cycle("ss_t5", S_T5, 16'h0805, 5'b0);
    step();
    expect_cycle("ss_idle", S_IDLE, 16'h0000, 5'b0);
    step();
    expect_cycle("ss_t0", S_T0, 16'hF000, 5'b0);
    chk("ss_count", 32'(instr_count), 32'd1);
    stop = 1'b0;
    for (int i = 0; i < 16; i++) begin
      for (int c = 0; c < 7; c++) step();
      if (i == 14) chk("wrap_zero", 32'(instr_count), 32'd0);
      if (i == 15) chk("wrap_one", 32'(instr_count), 32'd1);
    end
    expect_cycle("wrap_t0", S_T0, 16'hF000, 5'b0);

    // Reset in the middle of T4.
    for (int i = 0; i < 5; i++) step();
    expect_cycle("mid_t4", S_T4, 16'h100A, 5'b01011);
    clear = 1'b0;
    step();
    check_reset("mid_clear");
    clear = 1'b1; start = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/alu_seq_ctrl.md
# alu_seq_ctrl

Multi-cycle control FSM for the Mini-SRC datapath. It sequences instruction fetch and R-format ALU instructions (add, sub, shr, shra, shl, ror, rol, and, or) through the bus, register file, Y/Z registers and the 32-bit ALU. It waits on a memory-ready handshake and bounds that wait with a timeout. It halts on illegal opcodes, halt instructions or bus errors, and counts retired instructions.

## Interface
Parameters:
- MEM_TIMEOUT, 16: maximum cycles spent in the memory-wait state before a bus error is declared (≥1).
- CNT_W, 16: width of the retired-instruction counter.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- clear  in  1  reset; synchronous, active-low.
- start  in  1  level; begins or continues execution from IDLE.
- stop  in  1  level; sampled in T5 and returns the FSM to IDLE after the current instruction.
- ir  in  32  instruction register contents; opcode = ir[31:27].
- mem_ready  in  1  memory read data valid.
- pc_out, mar_in, inc_pc, z_in, z_lo_out, pc_in, mem_read, mdr_in, mdr_out, ir_in, y_in, gra, grb, grc, r_out, r_in  out  1 each  datapath control strobes.
- alu_op  out  5  ALU opcode.
- run  out  1  high in every state except IDLE and HALT.
- illegal  out  1  sticky: an illegal opcode was decoded.
- bus_err  out  1  sticky: memory timeout.
- instr_count  out  CNT_W  retired instructions; wraps modulo 2^CNT_W.

## Operation
- States: IDLE, T0, T1, T1W, T2, T3, T4, T5, HALT. State is registered. Strobes are Moore outputs decoded from state (and ir in T3/T4); strobes not listed for a state are 0.
- IDLE: all strobes 0. Goes to T0 when start=1.
- T0: pc_out, mar_in, inc_pc, z_in; alu_op=0. Goes to T1.
- T1: z_lo_out, pc_in, asserted for exactly one cycle. Goes to T1W.
- T1W: mem_read, mdr_in. Goes to T2 on mem_ready=1. If the wait counter reaches MEM_TIMEOUT with mem_ready=0: set bus_err, go to HALT. mem_ready=1 in the limit cycle wins, and the FSM goes to T2.
- T2: mdr_out, ir_in. Goes to T3.
- T3, legal opcode (00011–01011): gra, r_out, y_in; goes to T4.
- T3, opcode 11011 (halt): no strobes; goes to HALT; illegal stays 0.
- T3, any other opcode: no strobes; set illegal; goes to HALT.
- T4: grb, r_out, z_in; alu_op=ir[31:27]. Goes to T5.
- T5: z_lo_out, grc, r_in; instr_count increments on exit. Goes to IDLE if stop=1, else to T0.
- HALT: all strobes 0, run=0. Only clear exits HALT.
- alu_op is 0 in every state except T4.

## Timing
- Reset (clear=0 at an edge): state=IDLE; every strobe, alu_op, run, illegal, bus_err=0; instr_count=0; wait counter=0.
- Reset has priority over every transition, including mid-instruction and in HALT.
- No-wait instruction (mem_ready already high on entering T1W): T0, T1, T1W, T2, T3, T4, T5 = 7 cycles.
- Each extra wait cycle adds 1 cycle.
- The wait counter is cleared on every entry to T1W and counts cycles spent in T1W.
- instr_count increments at the T5 exit edge and is visible the following cycle.
- start is ignored outside IDLE.
- stop is ignored outside T5.
- Simultaneous stop=1 and start=1 in T5: go to IDLE. From IDLE, start=1 re-enters T0 on the next edge.

## Structure
- Shared package alu_seq_pkg holds:
  - opcode constants OP_ADD=5'b00011 … OP_OR=5'b01011 and OP_HALT=5'b11011;
  - state encoding constants;
  - the function is_alu_op(opcode).
- The ALU module consumes the same opcode constants.
- One sub-module, mem_wait_timer: a clearable up-counter with a terminal-count flag at MEM_TIMEOUT.

## Test plan
- Reset, then start=1, ir=0x18000000 (add), mem_ready=1: strobes follow T0…T5 in 7 cycles; alu_op=00011 only in T4; instr_count=1.
- mem_ready delayed 3 cycles: T1W lasts 4 cycles, mem_read and mdr_in high throughout; the instruction completes in 10 cycles with no bus_err.
- MEM_TIMEOUT=4, mem_ready held 0: bus_err=1 and run=0 at cycle 4 of T1W; a later mem_ready=1 changes nothing; clear restores the reset state.
- ir opcode 11111: illegal=1 with no strobes in T3, then HALT; opcode 11011: HALT with illegal=0.
- stop=1 during T5 with start=1: return to IDLE, then T0 on the next edge. Run 2^CNT_W+1 instructions with CNT_W=4: instr_count wraps to 1.
- clear=0 during T4: next cycle all outputs 0 and state IDLE; instr_count unchanged from its reset value of 0.
